// File: rtl/multicycle_control_fsm_if.sv
// ============================================================================
// Module      : multicycle_control_fsm_if
// Description : Control bus between the multicycle MIPS sequencer and its
//               datapath: opcode/ready inputs, mux selects, write strobes and
//               status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;
    logic       bus_error;

    // Sequencer side: consumes opcode/ready, drives every control line.
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op, bus_error
    );

    // Datapath side: supplies opcode/ready, obeys the control lines.
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op, bus_error
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Multicycle MIPS sequencing controller. Walks each instruction
//               through fetch/decode/execute/memory/writeback, stalls on
//               mem_ready, aborts memory accesses after MAX_WAIT not-ready
//               cycles and flags unsupported opcodes.
//               Optional feature macro: MC_ADDI_EN (adds addi support).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
    parameter int MAX_WAIT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_fsm_if.master   bus
);

    localparam int            CW        = $clog2(MAX_WAIT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            mem_state;
    logic            timeout;

    // State and wait-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state, wait-counter and Moore output decode (FETCH strobes gated by mem_ready).
    always_comb begin
        state_d           = state_q;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.illegal_op    = 1'b0;
        bus.state         = state_q;

        // Only the three states that wait on memory can time out; reset masks the abort.
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout   = rst_n && mem_state && !bus.mem_ready && (wait_q == WAIT_LAST);
        bus.bus_error = timeout;

        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:       state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d        = S_FETCH;
                        bus.illegal_op = rst_n;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                if (bus.opcode == OP_LW)      state_d = S_MEMRD;
                else if (bus.opcode == OP_SW) state_d = S_MEMWR;
                else                          state_d = S_FETCH;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
                state_d       = S_FETCH;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
`endif
            default: begin
                // Unreachable codes: all outputs stay 0, recover to FETCH.
                state_d = S_FETCH;
            end
        endcase

        // Abort overrides the normal transition; a FETCH abort refetches the same PC.
        if (timeout) state_d = S_FETCH;

        // Counter tracks consecutive not-ready cycles within one memory state.
        if ((state_d != state_q) || bus.mem_ready || timeout || !mem_state)
            wait_d = '0;
        else
            wait_d = wait_q + WAIT_ONE;
    end

endmodule

`default_nettype wire
